// File: rtl/min_pkg.sv
// Shared definitions for the min1/min2 extraction and spreading stages.
// Holds the default distance width, default node count, the distance and
// node-index types, and the spreader FSM state encoding.
package min_pkg;

  localparam int ED_W    = 16;
  localparam int N_NODES = 8;
  localparam int NODE_W  = $clog2(N_NODES) + 1;

  typedef logic [ED_W-1:0]   ed_t;
  typedef logic [NODE_W-1:0] node_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/min_spreader_sat_offset_sub.sv
// Unsigned saturating subtract of a fixed offset: values at or below the
// offset clamp to zero instead of wrapping around.
module sat_offset_sub
  import min_pkg::*;
#(
  parameter int W      = min_pkg::ED_W,
  parameter int OFFSET = 1
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);

  localparam logic [W-1:0] OFF = W'(OFFSET);

  // Clamp at zero so a small distance never wraps to a huge one
  always_comb begin
    result = '0;
    if (value > OFF) begin
      result = value - OFF;
    end
  end

endmodule

// File: rtl/min_spreader.sv
// Expands a (min1, min2, min1_node) summary into one distance per node:
// every node gets min1 except the node that produced min1, which gets min2.
// Optional feature: define MINSUM_OFFSET_EN to subtract OFFSET (saturating
// at zero) from both distances as they are captured.
module min_spreader #(
  parameter int N_NODES = min_pkg::N_NODES,
  parameter int ED_W    = min_pkg::ED_W,
  parameter int NODE_W  = $clog2(N_NODES) + 1,
  parameter int OFFSET  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ED_W-1:0]   min1_ed,
  input  logic [ED_W-1:0]   min2_ed,
  input  logic [NODE_W-1:0] min1_node,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NODE_W-1:0] out_node,
  output logic [ED_W-1:0]   out_ed,
  output logic              out_last
);

  import min_pkg::*;

  localparam logic [NODE_W-1:0] LAST_IDX = NODE_W'(N_NODES - 1);

  state_t            state_q;
  state_t            state_d;
  logic [NODE_W-1:0] idx_q;
  logic [NODE_W-1:0] node_q;
  logic [ED_W-1:0]   min1_q;
  logic [ED_W-1:0]   min2_q;
  logic [ED_W-1:0]   min1_in;
  logic [ED_W-1:0]   min2_in;
  logic              emit;
  logic              last;
  logic              load_xfer;
  logic              out_xfer;

`ifdef MINSUM_OFFSET_EN
  sat_offset_sub #(.W(ED_W), .OFFSET(OFFSET)) u_sub_min1 (
    .value  (min1_ed),
    .result (min1_in)
  );

  sat_offset_sub #(.W(ED_W), .OFFSET(OFFSET)) u_sub_min2 (
    .value  (min2_ed),
    .result (min2_in)
  );
`else
  assign min1_in = min1_ed;
  assign min2_in = min2_ed;
`endif

  assign emit       = (state_q == EMIT);
  assign last       = emit && (idx_q == LAST_IDX);
  assign out_xfer   = emit && out_ready;
  assign load_ready = (state_q == IDLE) || (last && out_ready);
  assign load_xfer  = load_valid && load_ready;

  assign out_valid = emit;
  assign out_node  = idx_q;
  assign out_last  = last;
  assign out_ed    = !emit ? '0 : ((idx_q == node_q) ? min2_q : min1_q);

  // Next state: start streaming on a load, stop after the last beat unless
  // a new summary is taken on that same edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load_xfer) state_d = EMIT;
      EMIT: if (out_xfer && last && !load_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the summary on a load and walk the node index on each beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      node_q <= '0;
      min1_q <= '0;
      min2_q <= '0;
    end else if (load_xfer) begin
      idx_q  <= '0;
      node_q <= min1_node;
      min1_q <= min1_in;
      min2_q <= min2_in;
    end else if (out_xfer) begin
      idx_q <= last ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_min_spreader.sv
// Self-checking bench for min_spreader: directed scenarios followed by random
// traffic, compared against a queue of expected beats built per summary.
module tb_min_spreader;

  localparam int N_NODES = 8;
  localparam int ED_W    = 16;
  localparam int NODE_W  = $clog2(N_NODES) + 1;
  localparam int OFFSET  = 2;

  typedef struct {
    int          node;
    logic [15:0] ed;
    logic        last;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic              load_valid;
  logic              load_ready;
  logic [ED_W-1:0]   min1_ed;
  logic [ED_W-1:0]   min2_ed;
  logic [NODE_W-1:0] min1_node;
  logic              out_valid;
  logic              out_ready;
  logic [NODE_W-1:0] out_node;
  logic [ED_W-1:0]   out_ed;
  logic              out_last;

  int    tests_run;
  int    tests_failed;
  beat_t exp_q[$];

  min_spreader #(
    .N_NODES (N_NODES),
    .ED_W    (ED_W),
    .NODE_W  (NODE_W),
    .OFFSET  (OFFSET)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .min1_ed    (min1_ed),
    .min2_ed    (min2_ed),
    .min1_node  (min1_node),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_node   (out_node),
    .out_ed     (out_ed),
    .out_last   (out_last)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] stored_value(input logic [15:0] v);
`ifdef MINSUM_OFFSET_EN
    if (int'(v) > OFFSET) return v - 16'(OFFSET);
    else return 16'd0;
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One cycle: check outputs against the model, drive inputs, check
  // load_ready, advance the model to what the next edge will do
  task automatic applyStimulus(input logic lv, input logic [15:0] m1,
                               input logic [15:0] m2, input int nd,
                               input logic ordy);
    logic exp_valid;
    logic exp_lr;
    exp_valid = (exp_q.size() > 0);
    checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("out_node", 32'(out_node), 32'(exp_q[0].node));
      checkOutput("out_ed",   32'(out_ed),   32'(exp_q[0].ed));
      checkOutput("out_last", 32'(out_last), 32'(exp_q[0].last));
    end
    load_valid = lv;
    min1_ed    = m1;
    min2_ed    = m2;
    min1_node  = NODE_W'(nd);
    out_ready  = ordy;
    #1;
    exp_lr = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
    checkOutput("load_ready", 32'(load_ready), 32'(exp_lr));
    if (exp_valid && ordy) void'(exp_q.pop_front());
    if (lv && exp_lr) begin
      for (int i = 0; i < N_NODES; i++) begin
        beat_t b;
        b.node = i;
        b.ed   = (i == nd) ? stored_value(m2) : stored_value(m1);
        b.last = (i == N_NODES - 1);
        exp_q.push_back(b);
      end
    end
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 16'h0, 0, ordy);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    load_valid   = 1'b0;
    min1_ed      = '0;
    min2_ed      = '0;
    min1_node    = '0;
    out_ready    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid",  32'(out_valid),  32'd0);
    checkOutput("rst_out_node",   32'(out_node),   32'd0);
    checkOutput("rst_out_ed",     32'(out_ed),     32'd0);
    checkOutput("rst_out_last",   32'(out_last),   32'd0);
    checkOutput("rst_load_ready", 32'(load_ready), 32'd1);
    rst_n = 1'b1;

    // Basic stream with out_ready held high
    applyStimulus(1'b1, 16'd3, 16'd7, 5, 1'b1);
    idleCycles(9, 1'b1);

    // Backpressure for three cycles at idx 2
    applyStimulus(1'b1, 16'd3, 16'd7, 5, 1'b1);
    idleCycles(2, 1'b1);
    idleCycles(3, 1'b0);
    idleCycles(7, 1'b1);

    // Back-to-back summary presented during the last beat
    applyStimulus(1'b1, 16'd3, 16'd7, 5, 1'b1);
    idleCycles(7, 1'b1);
    applyStimulus(1'b1, 16'd10, 16'd12, 0, 1'b1);
    idleCycles(9, 1'b1);

    // Out-of-range min1_node never matches
    applyStimulus(1'b1, 16'd20, 16'd30, 9, 1'b1);
    idleCycles(9, 1'b1);

    // Offset scenario values (plain pass-through unless offset is enabled)
    applyStimulus(1'b1, 16'd1, 16'd7, 4, 1'b1);
    idleCycles(9, 1'b1);

    // Reset pulse in the middle of a stream
    applyStimulus(1'b1, 16'd5, 16'd9, 1, 1'b1);
    idleCycles(4, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_out_node",  32'(out_node),  32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'd40, 16'hFFFF, 6, 1'b1);
    idleCycles(9, 1'b1);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      logic [15:0] m2r;
      m2r = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      applyStimulus(($urandom_range(0, 3) == 0), 16'($urandom), m2r,
                    int'($urandom_range(0, 11)), ($urandom_range(0, 3) != 0));
    end
    idleCycles(20, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
